// File: rtl/dqs_amble_gen.sv
// DQS preamble / postamble / interamble pattern generator, 2 DQS bits per PHY clock.
// Patterns are shifted MSB-first out of an 8-bit register; outputs are registered.
module dqs_amble_gen (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_enable,
   input  logic       i_pre_start,
   input  logic       i_post_start,
   input  logic       i_inter_start,
   input  logic [1:0] i_pre_sel,
   input  logic       i_post_sel,
   input  logic [3:0] i_gap,
   output logic [1:0] o_preamble_bits,
   output logic       o_preamble_valid,
   output logic       o_preamble_done,
   output logic       o_postamble_done,
   output logic [1:0] o_interamble_bits,
   output logic       o_interamble_done,
   output logic       o_busy
);

   typedef enum logic [1:0] {IDLE, PRE, POST, INTER} state_t;

   state_t     state;
   logic [2:0] cnt;
   logic [7:0] sh;

   logic [7:0] pre_pat, post_pat, inter_pat, ld_pat;
   logic [2:0] pre_len, post_len, inter_len, ld_len;
   state_t     ld_state;
   logic       ld, last;

   state_t     nx_state;
   logic [2:0] nx_cnt;
   logic [7:0] nx_sh;
   logic [1:0] nx_bits;
   logic       nx_done;

   // Patterns are held left-aligned so the first cycle's bits are always [7:6].
   always_comb begin
      case (i_pre_sel)
         2'b01:   begin pre_pat = 8'b0000_1000; pre_len = 3'd3; end
         2'b10:   begin pre_pat = 8'b0000_1010; pre_len = 3'd4; end
         default: begin pre_pat = 8'b0010_0000; pre_len = 3'd2; end
      endcase

      if (i_post_sel) begin
         post_pat = 8'b1000_0000;
         post_len = 3'd2;
      end else begin
         post_pat = 8'b0000_0000;
         post_len = 3'd1;
      end

      if (i_gap == 4'd0) begin
         inter_pat = 8'b1000_0000;
         inter_len = 3'd1;
      end else if (i_gap < {1'b0, pre_len}) begin
         inter_pat = pre_pat << {pre_len - i_gap[2:0], 1'b0};
         inter_len = i_gap[2:0];
      end else begin
         inter_pat = pre_pat;
         inter_len = pre_len;
      end
   end

   always_comb begin
      last     = (state == IDLE) || (cnt == 3'd0);
      ld       = 1'b1;
      ld_state = IDLE;
      ld_pat   = '0;
      ld_len   = 3'd1;
      // Interamble may pre-empt a running postamble at any cycle.
      if (i_inter_start && (last || state == POST)) begin
         ld_state = INTER;
         ld_pat   = inter_pat;
         ld_len   = inter_len;
      end else if (i_pre_start && last) begin
         ld_state = PRE;
         ld_pat   = pre_pat;
         ld_len   = pre_len;
      end else if (i_post_start && last) begin
         ld_state = POST;
         ld_pat   = post_pat;
         ld_len   = post_len;
      end else begin
         ld = 1'b0;
      end
   end

   always_comb begin
      nx_state = IDLE;
      nx_cnt   = '0;
      nx_sh    = '0;
      nx_bits  = '0;
      nx_done  = 1'b0;
      if (ld) begin
         nx_state = ld_state;
         nx_cnt   = ld_len - 3'd1;
         nx_sh    = {ld_pat[5:0], 2'b00};
         nx_bits  = ld_pat[7:6];
         nx_done  = (ld_len == 3'd1);
      end else if (!last) begin
         nx_state = state;
         nx_cnt   = cnt - 3'd1;
         nx_sh    = {sh[5:0], 2'b00};
         nx_bits  = sh[7:6];
         nx_done  = (cnt == 3'd1);
      end
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         state             <= IDLE;
         cnt               <= '0;
         sh                <= '0;
         o_preamble_bits   <= '0;
         o_preamble_valid  <= 1'b0;
         o_preamble_done   <= 1'b0;
         o_postamble_done  <= 1'b0;
         o_interamble_bits <= '0;
         o_interamble_done <= 1'b0;
         o_busy            <= 1'b0;
      end else if (i_enable) begin
         state             <= nx_state;
         cnt               <= nx_cnt;
         sh                <= nx_sh;
         o_preamble_bits   <= (nx_state == PRE) ? nx_bits : 2'b00;
         o_preamble_valid  <= (nx_state == PRE);
         o_preamble_done   <= (nx_state == PRE) && nx_done;
         o_postamble_done  <= (nx_state == POST) && nx_done;
         o_interamble_bits <= (nx_state == INTER) ? nx_bits : 2'b00;
         o_interamble_done <= (nx_state == INTER) && nx_done;
         o_busy            <= (nx_state != IDLE);
      end
   end

endmodule

// File: tb/tb_dqs_amble_gen.sv
// Scoreboard bench for dqs_amble_gen: stimulus queues expected per-cycle outputs,
// a negedge monitor pops one entry for every busy cycle.
module tb_dqs_amble_gen;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       en = 1'b0;
   logic       pre_s = 1'b0, post_s = 1'b0, inter_s = 1'b0;
   logic [1:0] pre_sel = 2'b00;
   logic       post_sel = 1'b0;
   logic [3:0] gap = 4'd0;
   logic [1:0] pre_bits, inter_bits;
   logic       pre_valid, pre_done, post_done, inter_done, busy;

   logic [7:0] expq[$];
   int         errors = 0;
   int         checks = 0;

   dqs_amble_gen dut (
      .i_clk            (clk),
      .i_rst            (rst),
      .i_enable         (en),
      .i_pre_start      (pre_s),
      .i_post_start     (post_s),
      .i_inter_start    (inter_s),
      .i_pre_sel        (pre_sel),
      .i_post_sel       (post_sel),
      .i_gap            (gap),
      .o_preamble_bits  (pre_bits),
      .o_preamble_valid (pre_valid),
      .o_preamble_done  (pre_done),
      .o_postamble_done (post_done),
      .o_interamble_bits(inter_bits),
      .o_interamble_done(inter_done),
      .o_busy           (busy)
   );

   always #5 clk = ~clk;

   // Packed view: {pre_bits, pre_valid, pre_done, post_done, inter_bits, inter_done}
   logic [7:0] got;
   assign got = {pre_bits, pre_valid, pre_done, post_done, inter_bits, inter_done};

   function automatic logic [7:0] P(input logic [1:0] b, input logic d);
      return {b, 1'b1, d, 1'b0, 2'b00, 1'b0};
   endfunction
   function automatic logic [7:0] Q(input logic d);
      return {2'b00, 1'b0, 1'b0, d, 2'b00, 1'b0};
   endfunction
   function automatic logic [7:0] I(input logic [1:0] b, input logic d);
      return {2'b00, 1'b0, 1'b0, 1'b0, b, d};
   endfunction

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got=%b expected=%b at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (busy === 1'b1) begin
         if (expq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_busy: got=%b expected=idle at %0t", got, $time);
         end else begin
            check("pattern", got, expq.pop_front());
         end
      end else begin
         check("idle_outputs", got, 8'h00);
         checks++;
         if (expq.size() != 0) begin
            errors++;
            $display("FAIL gap: got=idle expected=%b at %0t", expq[0], $time);
            void'(expq.pop_front());
         end
      end
   end

   task automatic pulse(input logic [2:0] w);
      {inter_s, pre_s, post_s} = w;
      @(posedge clk);
      #1 {inter_s, pre_s, post_s} = 3'b000;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      #1 rst = 1'b0;
      #2 check("reset_outputs", got, 8'h00);
      check("reset_busy", {7'd0, busy}, 8'h00);
      idle(2);
      rst = 1'b1;
      en  = 1'b1;
      idle(2);

      // 4-cycle preamble
      pre_sel = 2'b10;
      pulse(3'b010);
      expq.push_back(P(2'b00, 0)); expq.push_back(P(2'b00, 0));
      expq.push_back(P(2'b10, 0)); expq.push_back(P(2'b10, 1));
      idle(6);

      pre_sel = 2'b01;
      pulse(3'b010);
      expq.push_back(P(2'b00, 0)); expq.push_back(P(2'b00, 0)); expq.push_back(P(2'b10, 1));
      idle(5);

      pre_sel = 2'b11;
      pulse(3'b010);
      expq.push_back(P(2'b00, 0)); expq.push_back(P(2'b10, 1));
      idle(4);

      // post start in a non-last preamble cycle is ignored
      pre_sel = 2'b10;
      pulse(3'b010);
      expq.push_back(P(2'b00, 0)); expq.push_back(P(2'b00, 0));
      expq.push_back(P(2'b10, 0)); expq.push_back(P(2'b10, 1));
      pulse(3'b001);
      idle(6);

      // postamble then back-to-back preamble
      post_sel = 1'b1;
      pre_sel  = 2'b00;
      pulse(3'b001);
      expq.push_back(Q(0)); expq.push_back(Q(1));
      idle(1);
      pulse(3'b010);
      expq.push_back(P(2'b00, 0)); expq.push_back(P(2'b10, 1));
      idle(4);

      post_sel = 1'b0;
      pulse(3'b001);
      expq.push_back(Q(1));
      idle(3);

      // interamble truncation; gap change mid-pattern has no effect
      pre_sel = 2'b10;
      gap     = 4'd2;
      pulse(3'b100);
      gap = 4'd0;
      expq.push_back(I(2'b10, 0)); expq.push_back(I(2'b10, 1));
      idle(4);

      pulse(3'b100);
      expq.push_back(I(2'b10, 1));
      idle(3);

      gap = 4'd3;
      pulse(3'b100);
      expq.push_back(I(2'b00, 0)); expq.push_back(I(2'b10, 0)); expq.push_back(I(2'b10, 1));
      idle(5);

      pre_sel = 2'b01;
      gap     = 4'd9;
      pulse(3'b100);
      expq.push_back(I(2'b00, 0)); expq.push_back(I(2'b00, 0)); expq.push_back(I(2'b10, 1));
      idle(5);

      // interamble aborts the first postamble cycle
      post_sel = 1'b1;
      pre_sel  = 2'b00;
      gap      = 4'd1;
      pulse(3'b001);
      expq.push_back(Q(0));
      pulse(3'b100);
      expq.push_back(I(2'b10, 1));
      idle(4);

      // start priority
      pulse(3'b111);
      expq.push_back(I(2'b10, 1));
      idle(3);
      pulse(3'b011);
      expq.push_back(P(2'b00, 0)); expq.push_back(P(2'b10, 1));
      idle(4);

      // enable low for 3 cycles mid-preamble; pre_sel change is ignored
      pre_sel = 2'b01;
      pulse(3'b010);
      expq.push_back(P(2'b00, 0));
      en      = 1'b0;
      pre_sel = 2'b10;
      repeat (3) expq.push_back(P(2'b00, 0));
      expq.push_back(P(2'b00, 0)); expq.push_back(P(2'b10, 1));
      repeat (3) @(posedge clk);
      #1 en = 1'b1;
      idle(4);

      // asynchronous reset mid-preamble
      pulse(3'b010);
      expq.push_back(P(2'b00, 0));
      @(negedge clk);
      #1 rst = 1'b0;
      #1 check("async_reset_outputs", got, 8'h00);
      check("async_reset_busy", {7'd0, busy}, 8'h00);
      idle(2);
      rst     = 1'b1;
      pre_sel = 2'b00;
      idle(1);
      pulse(3'b010);
      expq.push_back(P(2'b00, 0)); expq.push_back(P(2'b10, 1));
      idle(4);

      check("queue_drained", 8'(expq.size()), 8'h00);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
